// File: rtl/pulse_width_classifier.sv
// pulse_width_classifier
// Multi-channel pulse width measurement and classification. Each channel
// measures the exact width of complete pulses of its selected polarity. It
// reports the width with a one-cycle strobe and classifies it against a
// shared [min_width, max_width] window. A live flag marks pulses that are
// still running and are already longer than max_width.

module pulse_width_classifier #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CHANNELS-1:0]          signal_in,
    input  logic [CHANNELS-1:0]          polarity,
    input  logic [WIDTH-1:0]             min_width,
    input  logic [WIDTH-1:0]             max_width,
    output logic [CHANNELS-1:0]          width_valid,
    output logic [CHANNELS*WIDTH-1:0]    width_out,
    output logic [CHANNELS-1:0]          in_range,
    output logic [CHANNELS-1:0]          too_short,
    output logic [CHANNELS-1:0]          too_long,
    output logic [CHANNELS-1:0]          overflow,
    output logic [CHANNELS-1:0]          long_active
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    // Per-channel measurement state.
    logic [CHANNELS-1:0]            act;
    logic [CHANNELS-1:0]            act_prev_q, act_prev_d;
    logic [CHANNELS-1:0]            armed_q,    armed_d;
    logic [CHANNELS-1:0]            sat_q,      sat_d;
    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q,      cnt_d;

    // Registered report outputs.
    logic [CHANNELS-1:0]            width_valid_q, width_valid_d;
    logic [CHANNELS-1:0][WIDTH-1:0] width_out_q,   width_out_d;
    logic [CHANNELS-1:0]            in_range_q,    in_range_d;
    logic [CHANNELS-1:0]            too_short_q,   too_short_d;
    logic [CHANNELS-1:0]            too_long_q,    too_long_d;
    logic [CHANNELS-1:0]            overflow_q,    overflow_d;

    // The active level follows polarity. The XNOR passes signal_in through
    // when polarity=1 and inverts it when polarity=0.
    assign act = ~(signal_in ^ polarity);

    // Next-state logic for every channel: edge detection, counting, reporting.
    always_comb begin
        // NOTE: every _d signal is first given its hold value, so no path through
        // the if/else tree can leave a signal unassigned and infer a latch.
        act_prev_d    = act;
        armed_d       = armed_q;
        sat_d         = sat_q;
        cnt_d         = cnt_q;
        width_valid_d = '0;
        width_out_d   = width_out_q;
        in_range_d    = in_range_q;
        too_short_d   = too_short_q;
        too_long_d    = too_long_q;
        overflow_d    = overflow_q;

        if (!enable) begin
            // Abandon any pulse in progress. Reports and flags keep their last values.
            cnt_d   = '0;
            armed_d = '0;
            sat_d   = '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (act[c] && !act_prev_q[c]) begin
                    // Leading edge: this edge is the first one that samples the pulse.
                    cnt_d[c]   = CNT_ONE;
                    armed_d[c] = 1'b1;
                    sat_d[c]   = 1'b0;
                end else if (act[c] && act_prev_q[c] && armed_q[c]) begin
                    // Continuing pulse: count, or saturate and remember that.
                    if (cnt_q[c] == CNT_MAX) begin
                        sat_d[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CNT_ONE;
                    end
                end else if (!act[c] && act_prev_q[c] && armed_q[c]) begin
                    // Trailing edge: report the width and classify it. The too_short
                    // test takes priority, so exactly one flag is set even when
                    // min_width > max_width.
                    width_out_d[c]   = cnt_q[c];
                    width_valid_d[c] = 1'b1;
                    overflow_d[c]    = sat_q[c];
                    in_range_d[c]    = 1'b0;
                    too_short_d[c]   = 1'b0;
                    too_long_d[c]    = 1'b0;
                    if (cnt_q[c] < min_width) begin
                        too_short_d[c] = 1'b1;
                    end else if (cnt_q[c] > max_width) begin
                        too_long_d[c]  = 1'b1;
                    end else begin
                        in_range_d[c]  = 1'b1;
                    end
                    cnt_d[c]   = '0;
                    armed_d[c] = 1'b0;
                end
                // An unarmed active level means the line was already active when
                // enable rose. Ignoring it means partial pulses are never reported.
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the value its _d signal had before this edge.
        if (rst) begin
            // NOTE: reset clears every register, report values included. The state
            // is small, and clearing it lets all outputs read 0 straight after reset.
            act_prev_q    <= '0;
            armed_q       <= '0;
            sat_q         <= '0;
            cnt_q         <= '0;
            width_valid_q <= '0;
            width_out_q   <= '0;
            in_range_q    <= '0;
            too_short_q   <= '0;
            too_long_q    <= '0;
            overflow_q    <= '0;
        end else begin
            act_prev_q    <= act_prev_d;
            armed_q       <= armed_d;
            sat_q         <= sat_d;
            cnt_q         <= cnt_d;
            width_valid_q <= width_valid_d;
            width_out_q   <= width_out_d;
            in_range_q    <= in_range_d;
            too_short_q   <= too_short_d;
            too_long_q    <= too_long_d;
            overflow_q    <= overflow_d;
        end
    end

    // Live "too long" flag, decoded from registers only.
    always_comb begin
        long_active = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            long_active[c] = armed_q[c] && (cnt_q[c] > max_width);
        end
    end

    assign width_valid = width_valid_q;
    assign width_out   = width_out_q;
    assign in_range    = in_range_q;
    assign too_short   = too_short_q;
    assign too_long    = too_long_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pulse_width_classifier.sv
// Testbench for pulse_width_classifier.
// The stimulus tasks push the expected reports into a queue. A monitor running
// on the falling clock edge pops one entry per width_valid strobe and compares.
// A second, narrow instance (one channel, WIDTH=4) covers saturation.

module tb_pulse_width_classifier;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [CH-1:0]   signal_in;
    logic [CH-1:0]   polarity;
    logic [W-1:0]    min_width;
    logic [W-1:0]    max_width;
    logic [CH-1:0]   width_valid;
    logic [CH*W-1:0] width_out;
    logic [CH-1:0]   in_range;
    logic [CH-1:0]   too_short;
    logic [CH-1:0]   too_long;
    logic [CH-1:0]   overflow;
    logic [CH-1:0]   long_active;

    logic [0:0]      sat_sig;
    logic [0:0]      sat_pol;
    logic [SW-1:0]   sat_min;
    logic [SW-1:0]   sat_max;
    logic [0:0]      sat_valid;
    logic [SW-1:0]   sat_wout;
    logic [0:0]      sat_inr;
    logic [0:0]      sat_short;
    logic [0:0]      sat_long;
    logic [0:0]      sat_ovf;
    logic [0:0]      sat_lact;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         ch;
        int         w;
        logic [2:0] cls;   // {in_range, too_short, too_long}
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t sat_q[$];

    always #5 clk = ~clk;

    pulse_width_classifier #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .signal_in(signal_in),
        .polarity(polarity), .min_width(min_width), .max_width(max_width),
        .width_valid(width_valid), .width_out(width_out), .in_range(in_range),
        .too_short(too_short), .too_long(too_long), .overflow(overflow),
        .long_active(long_active)
    );

    pulse_width_classifier #(.CHANNELS(1), .WIDTH(SW)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .signal_in(sat_sig),
        .polarity(sat_pol), .min_width(sat_min), .max_width(sat_max),
        .width_valid(sat_valid), .width_out(sat_wout), .in_range(sat_inr),
        .too_short(sat_short), .too_long(sat_long), .overflow(sat_ovf),
        .long_active(sat_lact)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] classify(input int w, input int mn, input int mx);
        if (w < mn)      return 3'b010;
        else if (w > mx) return 3'b001;
        else             return 3'b100;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_act(input int ch, input bit a);
        signal_in[ch] = polarity[ch] ? a : ~a;
    endtask

    task automatic push(input int ch, input int w, input bit ovf);
        exp_t e;
        e.ch  = ch;
        e.w   = w;
        e.cls = classify(w, int'(min_width), int'(max_width));
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Drive an n-cycle pulse on one channel, then the edge that samples its end.
    task automatic pulse(input int ch, input int n);
        set_act(ch, 1'b1);
        repeat (n) tick();
        set_act(ch, 1'b0);
        tick();
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int c = 0; c < CH; c++) begin
                if (width_valid[c]) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("spurious_valid_ch%0d", c), 32'(width_valid[c]), 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("report_channel", c, e.ch);
                        check($sformatf("width_ch%0d", c), 32'(width_out[c*W +: W]), e.w);
                        check($sformatf("class_ch%0d", c),
                              {29'd0, in_range[c], too_short[c], too_long[c]}, {29'd0, e.cls});
                        check($sformatf("overflow_ch%0d", c), 32'(overflow[c]), 32'(e.ovf));
                    end
                end
            end
            if (sat_valid[0]) begin
                if (sat_q.size() == 0) begin
                    check("spurious_valid_sat", 32'(sat_valid[0]), 32'd0);
                end else begin
                    exp_t e;
                    e = sat_q.pop_front();
                    check("width_sat", 32'(sat_wout), e.w);
                    check("class_sat", {29'd0, sat_inr[0], sat_short[0], sat_long[0]}, {29'd0, e.cls});
                    check("overflow_sat", 32'(sat_ovf[0]), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t se;
        rst       = 1'b1;
        enable    = 1'b0;
        polarity  = 4'b1011;     // ch2 measures low pulses
        signal_in = 4'b0100;     // every channel at its inactive level
        min_width = 8'd3;
        max_width = 8'd10;
        sat_sig   = 1'b0;
        sat_pol   = 1'b1;
        sat_min   = 4'd3;
        sat_max   = 4'd10;

        // Reset with toggling inputs: every output must read 0.
        for (int i = 0; i < 2; i++) begin
            signal_in = 4'($urandom);
            sat_sig   = 1'($urandom);
            enable    = 1'($urandom);
            tick();
        end
        check("rst_valid",     32'(width_valid), 0);
        check("rst_width",     width_out,        0);
        check("rst_in_range",  32'(in_range),    0);
        check("rst_too_short", 32'(too_short),   0);
        check("rst_too_long",  32'(too_long),    0);
        check("rst_overflow",  32'(overflow),    0);
        check("rst_long_act",  32'(long_active), 0);
        check("rst_sat_width", 32'(sat_wout),    0);
        signal_in = 4'b0100;
        sat_sig   = 1'b0;
        enable    = 1'b0;
        tick();
        rst = 1'b0;

        // Disabled: pulses on the inputs must produce no report.
        pulse(0, 5);
        pulse(3, 3);
        tick();
        check("disabled_width", width_out, 0);

        enable = 1'b1;
        tick();

        // Basic measurement and a single-cycle glitch.
        push(0, 5, 1'b0);
        pulse(0, 5);
        tick();
        push(0, 1, 1'b0);
        pulse(0, 1);
        tick();

        // 12-cycle pulse on ch1: the live flag is set from cnt=11 until the report.
        push(1, 12, 1'b0);
        set_act(1, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            check($sformatf("long_active_cnt%0d", i), 32'(long_active[1]), (i >= 11) ? 1 : 0);
        end
        set_act(1, 1'b0);
        tick();
        check("long_active_after_end", 32'(long_active[1]), 0);
        tick();

        // Window boundaries.
        push(1, 3, 1'b0);  pulse(1, 3);  tick();
        push(1, 10, 1'b0); pulse(1, 10); tick();
        push(1, 11, 1'b0); pulse(1, 11); tick();
        check("hold_width_ch1", 32'(width_out[1*W +: W]), 11);

        // Opposite polarity on ch2 concurrent with a high pulse on ch3.
        push(2, 4, 1'b0);
        push(3, 4, 1'b0);
        set_act(2, 1'b1);
        set_act(3, 1'b1);
        repeat (4) tick();
        set_act(2, 1'b0);
        set_act(3, 1'b0);
        tick();
        tick();

        // Inverted window: classified without error.
        min_width = 8'd8;
        max_width = 8'd4;
        push(0, 6, 1'b0);
        pulse(0, 6);
        tick();
        min_width = 8'd3;
        max_width = 8'd10;

        // Enable rises mid-pulse: that pulse is dropped, the next one is reported.
        enable = 1'b0;
        set_act(0, 1'b1);
        repeat (2) tick();
        enable = 1'b1;
        repeat (3) tick();
        set_act(0, 1'b0);
        repeat (2) tick();
        push(0, 7, 1'b0);
        pulse(0, 7);
        tick();

        // Disabled again: the last report holds.
        enable = 1'b0;
        pulse(0, 4);
        check("hold_width_disabled", 32'(width_out[0 +: W]), 7);
        check("hold_in_range_disabled", 32'(in_range[0]), 1);
        enable = 1'b1;
        tick();

        // Reset mid-pulse discards the pulse and clears the reports.
        set_act(0, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        set_act(0, 1'b0);
        check("midrst_width", width_out, 0);
        check("midrst_in_range", 32'(in_range), 0);
        rst = 1'b0;
        repeat (2) tick();
        push(0, 6, 1'b0);
        pulse(0, 6);
        tick();

        // Saturation on the 4-bit instance.
        se.ch  = 0;
        se.w   = 15;
        se.cls = classify(15, int'(sat_min), int'(sat_max));
        se.ovf = 1'b1;
        sat_q.push_back(se);
        sat_sig = 1'b1;
        repeat (20) tick();
        sat_sig = 1'b0;
        tick();
        repeat (3) tick();

        check("pending_reports", exp_q.size(), 0);
        check("pending_sat_reports", sat_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
